// File: rtl/packet_receiver_if.sv
// Purpose: bundles the serial line, flow-control and FIFO read-side signals of packet_receiver.
// Latency: none; this is wiring only.
// Backpressure: xoffOut travels upstream to the transmitter, rdEn pops the head word.
interface packet_receiver_if #(
  parameter int logDEPTH  = 4,
  parameter int WORDWIDTH = 58
);
  logic                 datIn;
  logic                 xoffOut;
  logic                 rdEn;
  logic [WORDWIDTH-1:0] pktDout;
  logic [3:0]           pktId;
  logic                 empty;
  logic [logDEPTH:0]    fifoCount;
  logic [15:0]          pktCnt;
  logic                 ovfErr;
  logic                 clrErr;

  // Host side: drives the line and the read/clear controls, observes status.
  modport master (
    output datIn, rdEn, clrErr,
    input  xoffOut, pktDout, pktId, empty, fifoCount, pktCnt, ovfErr
  );

  // Receiver side.
  modport slave (
    input  datIn, rdEn, clrErr,
    output xoffOut, pktDout, pktId, empty, fifoCount, pktCnt, ovfErr
  );
endinterface

// File: rtl/packet_receiver.sv
// Purpose: first-word-fall-through FIFO with occupancy count and full/almost-full flags.
// Latency: a written word is visible on rd_dat the cycle after the write edge.
// Backpressure: writes while full are ignored, and so are pops while empty.
module packet_receiver_fifo #(
  parameter int LOG_DEPTH = 4,
  parameter int WIDTH     = 58
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_vld,
  input  logic [WIDTH-1:0]     wr_dat,
  input  logic                 rd_rdy,
  output logic [WIDTH-1:0]     rd_dat,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic [LOG_DEPTH:0]   count
);
  localparam int                 DEPTH    = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] FULL_CNT = DEPTH[LOG_DEPTH:0];
  localparam logic [LOG_DEPTH:0] AF_CNT   = FULL_CNT - 1'b1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic                 push;
  logic                 pop;

  // Flags come from the registered count, so full is the pre-read value.
  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign almost_full = (count >= AF_CNT);
  assign push        = wr_vld & ~full;
  assign pop         = rd_rdy & ~empty;
  assign rd_dat      = mem[rd_ptr];

  // Storage array: contents are don't-care after reset, so it has no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks push/pop, unchanged when both fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// Purpose: deserialises start-bit framed packets from the chain and queues them for the host.
// Latency: a word reaches pktDout the cycle after DONE, 60 cycles after its start bit.
// Backpressure: xoffOut is raised when full, or when almost full with a packet in flight.
module packet_receiver #(
  parameter int logDEPTH  = 4,
  parameter int WORDWIDTH = 58
) (
  input  logic              clk,
  input  logic              rst,
  packet_receiver_if.slave  bus
);
  localparam int               CNT_W    = $clog2(WORDWIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORDWIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [CNT_W-1:0]     bit_cnt;
  logic [WORDWIDTH-1:0] shift_reg;
  logic [15:0]          pkt_cnt_q;
  logic                 ovf_err_q;

  logic                 pkt_wr_vld;
  logic                 pkt_drop;
  logic [WORDWIDTH-1:0] fifo_rd_dat;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 fifo_almost_full;
  logic [logDEPTH:0]    fifo_count;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a 1 in IDLE frames a packet, DONE is a single dead cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.datIn) state_d = S_SHIFT;
      S_SHIFT: if (bit_cnt == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: the DONE cycle either hands the word to the FIFO or drops it.
  always_comb begin
    pkt_wr_vld = 1'b0;
    pkt_drop   = 1'b0;
    if (state_q == S_DONE) begin
      if (fifo_full) begin
        pkt_drop = 1'b1;
      end else begin
        pkt_wr_vld = 1'b1;
      end
    end
  end

  // Shifter: bit_cnt names the payload bit currently on the line, MSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= LAST_BIT;
      shift_reg <= '0;
    end else if (state_q == S_SHIFT) begin
      shift_reg <= {shift_reg[WORDWIDTH-2:0], bus.datIn};
      bit_cnt   <= (bit_cnt == '0) ? LAST_BIT : bit_cnt - 1'b1;
    end else begin
      bit_cnt   <= LAST_BIT;
    end
  end

  // Accepted-packet counter saturates at all-ones; clear beats a same-cycle accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q <= '0;
    end else if (bus.clrErr) begin
      pkt_cnt_q <= '0;
    end else if (pkt_wr_vld && (pkt_cnt_q != 16'hFFFF)) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  // Sticky overflow flag; clear beats a same-cycle drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err_q <= 1'b0;
    end else if (bus.clrErr) begin
      ovf_err_q <= 1'b0;
    end else if (pkt_drop) begin
      ovf_err_q <= 1'b1;
    end
  end

  packet_receiver_fifo #(
    .LOG_DEPTH (logDEPTH),
    .WIDTH     (WORDWIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .wr_vld      (pkt_wr_vld),
    .wr_dat      (shift_reg),
    .rd_rdy      (bus.rdEn),
    .rd_dat      (fifo_rd_dat),
    .empty       (fifo_empty),
    .full        (fifo_full),
    .almost_full (fifo_almost_full),
    .count       (fifo_count)
  );

  // xoff covers the packet already in flight when only one slot is left.
  assign bus.xoffOut   = fifo_full | (fifo_almost_full & (state_q != S_IDLE));
  assign bus.pktDout   = fifo_rd_dat;
  assign bus.pktId     = fifo_rd_dat[WORDWIDTH-1 -: 4];
  assign bus.empty     = fifo_empty;
  assign bus.fifoCount = fifo_count;
  assign bus.pktCnt    = pkt_cnt_q;
  assign bus.ovfErr    = ovf_err_q;
endmodule

// File: tb/tb_packet_receiver.sv
// Purpose: directed scenarios for packet_receiver with a scoreboard of expected FIFO words.
// Latency: inputs are driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: xoffOut is checked but deliberately not obeyed, so overflow can be provoked.
module tb_packet_receiver;
  localparam int LOGD  = 4;
  localparam int WW    = 58;
  localparam int DEPTH = 1 << LOGD;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  packet_receiver_if #(.logDEPTH(LOGD), .WORDWIDTH(WW)) bus ();

  packet_receiver #(.logDEPTH(LOGD), .WORDWIDTH(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            vectors     = 0;
  int            miscompares = 0;
  logic [WW-1:0] sb_q [$];
  logic [15:0]   exp_cnt;
  logic          exp_ovf;
  logic [WW-1:0] w;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.datIn = b;
    tick();
  endtask

  function automatic logic [WW-1:0] mk_word(input int k);
    logic [63:0] r;
    logic [31:0] kk;
    r  = {$urandom(), $urandom()};
    kk = k;
    return {kk[3:0], r[53:0]};
  endfunction

  // Start bit plus 58 data bits; returns in the DONE cycle.
  task automatic send_body(input logic [WW-1:0] word, input int xoff_exp);
    send_bit(1'b1);
    if (xoff_exp >= 0) check("xoff_first_shift", 64'(bus.xoffOut), 64'(xoff_exp));
    for (int i = WW - 1; i >= 0; i--) send_bit(word[i]);
  endtask

  // DONE cycle: optional pop and clear, scoreboard and counter model updated.
  task automatic finish_pkt(input logic [WW-1:0] word, input logic pop, input logic clr);
    logic accept;
    accept      = (sb_q.size() < DEPTH);
    bus.datIn   = 1'b0;
    bus.rdEn    = pop;
    bus.clrErr  = clr;
    if (pop && sb_q.size() > 0) begin
      check("head_pop_done", 64'(bus.pktDout), 64'(sb_q[0]));
      void'(sb_q.pop_front());
    end
    if (accept) sb_q.push_back(word);
    if (clr) exp_cnt = 16'd0;
    else if (accept && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    exp_ovf = clr ? 1'b0 : (exp_ovf | ~accept);
    tick();
    bus.rdEn   = 1'b0;
    bus.clrErr = 1'b0;
  endtask

  task automatic send_pkt(input logic [WW-1:0] word, input logic pop, input logic clr);
    send_body(word, -1);
    finish_pkt(word, pop, clr);
  endtask

  task automatic pop_one();
    bus.rdEn = 1'b1;
    if (sb_q.size() > 0) begin
      check("head_pop", 64'(bus.pktDout), 64'(sb_q[0]));
      void'(sb_q.pop_front());
    end
    tick();
    bus.rdEn = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 64'(bus.fifoCount), 64'(sb_q.size()));
    check({tag, "_empty"}, 64'(bus.empty), 64'(sb_q.size() == 0));
    check({tag, "_pktcnt"}, 64'(bus.pktCnt), 64'(exp_cnt));
    check({tag, "_ovf"}, 64'(bus.ovfErr), 64'(exp_ovf));
  endtask

  task automatic pulse_clr();
    bus.clrErr = 1'b1;
    exp_cnt    = 16'd0;
    exp_ovf    = 1'b0;
    tick();
    bus.clrErr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    bus.datIn  = 1'b0;
    bus.rdEn   = 1'b0;
    bus.clrErr = 1'b0;
    exp_cnt    = 16'd0;
    exp_ovf    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_status("reset");
    check("reset_xoff", 64'(bus.xoffOut), 64'(1'b0));

    // Single packet: empty during DONE, word visible the cycle after.
    w = 58'h2A5_5A5A_5A5A_5A5A;
    send_body(w, 0);
    check("empty_in_done", 64'(bus.empty), 64'(1'b1));
    finish_pkt(w, 1'b0, 1'b0);
    check("single_dout", 64'(bus.pktDout), 64'(58'h2A5_5A5A_5A5A_5A5A));
    check("single_id", 64'(bus.pktId), 64'(4'hA));
    check("single_cnt", 64'(bus.pktCnt), 64'(16'd1));
    check_status("single");
    pop_one();
    pulse_clr();
    check("clr_cnt", 64'(bus.pktCnt), 64'(16'd0));

    // Sixteen back-to-back packets fill the FIFO; the 17th is dropped.
    for (int k = 0; k < DEPTH; k++) begin
      w = mk_word(k);
      if (k == DEPTH - 1) check("xoff_af_idle", 64'(bus.xoffOut), 64'(1'b0));
      send_body(w, (k == DEPTH - 1) ? 1 : -1);
      finish_pkt(w, 1'b0, 1'b0);
    end
    check("full_count", 64'(bus.fifoCount), 64'(5'd16));
    check("full_xoff", 64'(bus.xoffOut), 64'(1'b1));
    w = mk_word(DEPTH);
    send_body(w, 1);
    finish_pkt(w, 1'b0, 1'b0);
    check("drop_ovf", 64'(bus.ovfErr), 64'(1'b1));
    check("drop_cnt", 64'(bus.pktCnt), 64'(16'd16));
    check_status("drop");

    // Drain in order, then a pop on empty must be ignored.
    for (int k = 0; k < DEPTH; k++) pop_one();
    check_status("drained");
    check("drained_xoff", 64'(bus.xoffOut), 64'(1'b0));
    pop_one();
    check_status("pop_empty");
    pulse_clr();
    check_status("clr_ovf");

    // Write and pop in the same DONE cycle with three words queued.
    for (int k = 0; k < 3; k++) send_pkt(mk_word(k + 3), 1'b0, 1'b0);
    check("conc_pre", 64'(bus.fifoCount), 64'(5'd3));
    send_pkt(mk_word(7), 1'b1, 1'b0);
    check("conc_count", 64'(bus.fifoCount), 64'(5'd3));
    check("conc_head", 64'(bus.pktDout), 64'(sb_q[0]));
    for (int k = 0; k < 3; k++) pop_one();
    check_status("conc_drained");

    // Reset while bit 20 is on the line; trailing bits are zero so no new frame starts.
    w = mk_word(9) & ~58'hF_FFFF;
    send_bit(1'b1);
    for (int i = WW - 1; i >= 0; i--) begin
      if (i == 20) begin
        bus.datIn = w[i];
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
      end else begin
        send_bit(w[i]);
      end
    end
    exp_cnt = 16'd0;
    exp_ovf = 1'b0;
    send_bit(1'b0);
    send_bit(1'b0);
    check_status("midrst");
    send_pkt(mk_word(11), 1'b0, 1'b0);
    check_status("after_rst");
    pop_one();

    // Saturation from a preloaded count, then clear wins over a same-cycle accept.
    force dut.pkt_cnt_q = 16'hFFFE;
    #1;
    release dut.pkt_cnt_q;
    exp_cnt = 16'hFFFE;
    send_pkt(mk_word(12), 1'b0, 1'b0);
    check("sat_first", 64'(bus.pktCnt), 64'(16'hFFFF));
    send_pkt(mk_word(13), 1'b0, 1'b0);
    check("sat_hold", 64'(bus.pktCnt), 64'(16'hFFFF));
    send_pkt(mk_word(14), 1'b0, 1'b1);
    check("clr_wins_cnt", 64'(bus.pktCnt), 64'(16'd0));
    check("clr_wins_ovf", 64'(bus.ovfErr), 64'(1'b0));
    check_status("sat");
    for (int k = 0; k < 3; k++) pop_one();
    check_status("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/packet_receiver.md
PACKET_RECEIVER -- requirements
Module: packet_receiver

Interface
REQ-001 SHALL have parameter logDEPTH, default 4, meaning log2 of receive FIFO depth (DEPTH = 2^logDEPTH words).
REQ-002 SHALL have parameter WORDWIDTH, default 58, meaning received word width: 4-bit chip ID followed by 54-bit payload.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 datIn  input  1  serial packet stream from the last chip of the chain: start bit 1, then 58 bits MSB first, then at least one idle 0.
REQ-006 xoffOut  output  1  back-pressure to the transmitting chip; 1 = do not start a new packet.
REQ-007 rdEn  input  1  pop request for the FIFO head word.
REQ-008 pktDout  output  58  FIFO head word, {ID[3:0], payload[53:0]}, valid when empty=0.
REQ-009 pktId  output  4  equals pktDout[57:54].
REQ-010 empty  output  1  FIFO holds no words.
REQ-011 fifoCount  output  logDEPTH+1  number of words in FIFO.
REQ-012 pktCnt  output  16  packets accepted into FIFO, saturating.
REQ-013 ovfErr  output  1  sticky: a complete packet was dropped because FIFO was full.
REQ-014 clrErr  input  1  clears ovfErr and pktCnt.

Function
REQ-015 Receiver FSM SHALL have states IDLE, SHIFT, DONE; reset state IDLE.
REQ-016 IDLE: datIn=1 at a clock edge -> SHIFT with bitCnt=57; datIn=0 -> stay IDLE.
REQ-017 SHIFT: each cycle shiftReg <= {shiftReg[56:0], datIn}, bitCnt decrements; in the cycle bitCnt==0, the last bit is shifted and next state is DONE.
REQ-018 DONE: lasts exactly one cycle, datIn ignored, next state IDLE; a start bit is recognised no earlier than the cycle after DONE.
REQ-019 In DONE with full=0, shiftReg SHALL be written to the FIFO; the word appears on pktDout (if FIFO was empty) on the first cycle after DONE.
REQ-020 In DONE with full=1, the word SHALL be dropped, ovfErr set to 1, and pktCnt unchanged; full is evaluated before any same-cycle read.
REQ-021 FIFO SHALL be first-word-fall-through; rdEn=1 with empty=0 pops the head at the clock edge; rdEn with empty=1 SHALL be ignored.
REQ-022 Simultaneous write and pop with 0<fifoCount<DEPTH SHALL leave fifoCount unchanged and preserve order.
REQ-023 Read/write pointers SHALL be logDEPTH bits and wrap modulo DEPTH; full = (fifoCount==DEPTH), empty = (fifoCount==0).
REQ-024 almostFull = (fifoCount >= DEPTH-1); xoffOut = full OR (almostFull AND state!=IDLE), combinational from registers only.
REQ-025 pktCnt SHALL increment by 1 per accepted packet and hold at 16'hFFFF.
REQ-026 clrErr=1 SHALL clear ovfErr and pktCnt next edge; if a drop or accept occurs in the same cycle, clear wins.

Reset
REQ-027 rst=1 at a clock edge SHALL force: state IDLE, bitCnt 57, shiftReg 0, pointers 0, fifoCount 0, empty 1, xoffOut 0, pktCnt 0, ovfErr 0; pktDout content is don't-care.
REQ-028 rst asserted mid-packet SHALL discard the partial packet; after release, remaining packet bits are treated as line data (a 1 starts a new packet).
REQ-029 rst SHALL take priority over rdEn, clrErr, and all FSM activity.

Verification
REQ-030 Single packet: start bit + 58'h2A5_5A5A_5A5A_5A5A on datIn -> empty falls one cycle after DONE, pktDout=58'h2A5_5A5A_5A5A_5A5A, pktId=4'hA, pktCnt=1.
REQ-031 Back-to-back: 16 packets, each separated by one idle 0, rdEn=0 -> fifoCount=16, full=1; xoffOut=1 from the first cycle of packet 16's SHIFT onward; a 17th packet sets ovfErr=1 and leaves pktCnt=16.
REQ-032 Drain order: after the previous scenario, rdEn=1 for 16 cycles -> pktDout sequence equals send order, empty=1 after the 16th pop, xoffOut=0.
REQ-033 Concurrent read/write: fifoCount=3 with rdEn=1 during DONE -> fifoCount remains 3, head advances by one word.
REQ-034 Mid-packet reset: rst pulsed while bitCnt=20 -> FIFO stays empty, pktCnt=0; next clean packet is received intact.
REQ-035 Saturation and clear: preload pktCnt to 16'hFFFE, accept 2 packets -> pktCnt=16'hFFFF; clrErr=1 -> pktCnt=0, ovfErr=0.
